// File: rtl/mesh_port_arbiter.sv
// Purpose: per-channel input FIFOs merged onto one mesh port by a round-robin arbiter.
// Latency: a push at edge k can show on pndng_o after edge k+1 (no bypass); pops stream back-to-back.
// Backpressure: full_o[i] per channel; a push into a full FIFO is dropped and latches ovf_o[i].
//
// Ports: clk_i/rst_i (sync active-high); push_i/data_in_i per-channel write side with
// full_o/ovf_o status; pndng_o/data_out_o/src_o/bcast_o registered mesh-side packet,
// consumed by pop_i.
// Build option: define MESH_ARB_BCAST_PRIO_EN to grant broadcast heads ahead of unicast heads.
module mesh_port_arbiter #(
  parameter int         CHANNELS   = 4,
  parameter int         PAKG_SIZE  = 32,
  parameter int         FIFO_DEPTH = 16,
  parameter logic [7:0] BDCST      = 8'hFF
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [CHANNELS-1:0]           push_i,
  input  logic [CHANNELS*PAKG_SIZE-1:0] data_in_i,
  output logic [CHANNELS-1:0]           full_o,
  output logic [CHANNELS-1:0]           ovf_o,
  output logic                          pndng_o,
  output logic [PAKG_SIZE-1:0]          data_out_o,
  output logic [$clog2(CHANNELS)-1:0]   src_o,
  output logic                          bcast_o,
  input  logic                          pop_i
);

  localparam int SW = $clog2(CHANNELS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {EMPTY = 1'b0, VALID = 1'b1} state_t;

  logic [PAKG_SIZE-1:0] mem [CHANNELS][FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr [CHANNELS];
  logic [PW-1:0]        rd_ptr [CHANNELS];
  logic [CW-1:0]        count  [CHANNELS];

  logic [CHANNELS-1:0]  full;
  logic [CHANNELS-1:0]  nonempty;
  logic [CHANNELS-1:0]  push_ok;
  logic [CHANNELS-1:0]  fifo_pop;
  logic [CHANNELS-1:0]  cand;
  logic [SW-1:0]        last_grant;
  logic [SW-1:0]        grant;
  logic                 grant_bc;
  logic                 found;
  logic                 load;
  logic [PAKG_SIZE-1:0] sel_dat;
  state_t               state;

  // Full is taken from the count before the edge, so a push and a pop in the
  // same cycle on a full FIFO still loses the push.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      nonempty[i] = (count[i] != '0);
      full[i]     = (count[i] == CW'(FIFO_DEPTH));
      push_ok[i]  = push_i[i] && !full[i];
    end
  end

  assign full_o = full;

`ifdef MESH_ARB_BCAST_PRIO_EN
  logic [CHANNELS-1:0] head_bc;

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      head_bc[i] = nonempty[i] && (mem[i][rd_ptr[i]][PAKG_SIZE-1 -: 8] == BDCST);
    end
  end
`endif

  // Candidate set: broadcast heads take precedence when the option is built in;
  // the same rotating search is then applied to whichever set is active.
  always_comb begin
    cand     = nonempty;
    grant_bc = 1'b0;
`ifdef MESH_ARB_BCAST_PRIO_EN
    if (|head_bc) begin
      cand     = head_bc;
      grant_bc = 1'b1;
    end
`endif
    grant = last_grant;
    found = 1'b0;
    for (int k = 1; k <= CHANNELS; k++) begin
      if (!found && cand[(int'(last_grant) + k) % CHANNELS]) begin
        grant = SW'((int'(last_grant) + k) % CHANNELS);
        found = 1'b1;
      end
    end
  end

  assign sel_dat = mem[grant][rd_ptr[grant]];
  // pop_i is only meaningful while a packet is presented.
  assign load    = (|nonempty) && ((state == EMPTY) || pop_i);

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      fifo_pop[i] = load && (grant == SW'(i));
    end
  end

  // FIFO bookkeeping; pointers wrap naturally because FIFO_DEPTH is a power of 2.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < CHANNELS; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
      ovf_o <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (push_ok[i])            wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (fifo_pop[i])           rd_ptr[i] <= rd_ptr[i] + 1'b1;
        if (push_i[i] && full[i])  ovf_o[i]  <= 1'b1;
        count[i] <= count[i] + CW'(push_ok[i]) - CW'(fifo_pop[i]);
      end
    end
  end

  // Storage has no reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (push_ok[i]) mem[i][wr_ptr[i]] <= data_in_i[i*PAKG_SIZE +: PAKG_SIZE];
      end
    end
  end

  // Output FSM with registered mesh-side outputs. A broadcast-priority grant
  // leaves last_grant alone so unicast rotation is not disturbed.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= EMPTY;
      pndng_o    <= 1'b0;
      data_out_o <= '0;
      src_o      <= '0;
      bcast_o    <= 1'b0;
      last_grant <= SW'(CHANNELS - 1);
    end else begin
      case (state)
        EMPTY: begin
          if (load) begin
            data_out_o <= sel_dat;
            src_o      <= grant;
            bcast_o    <= (sel_dat[PAKG_SIZE-1 -: 8] == BDCST);
            if (!grant_bc) last_grant <= grant;
            state      <= VALID;
            pndng_o    <= 1'b1;
          end
        end
        VALID: begin
          if (load) begin
            data_out_o <= sel_dat;
            src_o      <= grant;
            bcast_o    <= (sel_dat[PAKG_SIZE-1 -: 8] == BDCST);
            if (!grant_bc) last_grant <= grant;
          end else if (pop_i) begin
            state   <= EMPTY;
            pndng_o <= 1'b0;
          end
        end
        default: begin
          state   <= EMPTY;
          pndng_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mesh_port_arbiter.md
MESH_PORT_ARBITER -- requirements
Module: mesh_port_arbiter

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, number of terminal input channels (2..16).
REQ-002 SHALL have parameter PAKG_SIZE, default 32, packet width in bits (>=16).
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, per-channel FIFO entries (power of 2, >=2).
REQ-004 SHALL have parameter BDCST, default 8'hFF, destination-field value that marks a broadcast packet.
REQ-005 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_i, input, 1, reset; synchronous, active-high.
REQ-007 SHALL have port push_i, input, CHANNELS, per-channel write strobe.
REQ-008 SHALL have port data_in_i, input, CHANNELS*PAKG_SIZE, channel i packet at bits [i*PAKG_SIZE +: PAKG_SIZE].
REQ-009 SHALL have port full_o, output, CHANNELS, per-channel FIFO full.
REQ-010 SHALL have port ovf_o, output, CHANNELS, sticky flag for a dropped push.
REQ-011 SHALL have port pndng_o, output, 1, packet pending at the mesh side.
REQ-012 SHALL have port data_out_o, output, PAKG_SIZE, pending packet.
REQ-013 SHALL have port src_o, output, $clog2(CHANNELS), channel index of the pending packet.
REQ-014 SHALL have port bcast_o, output, 1, high when the pending packet's bits [PAKG_SIZE-1 -: 8] equal BDCST.
REQ-015 SHALL have port pop_i, input, 1, mesh consumes the pending packet.

Function
REQ-016 SHALL provide one FIFO per channel; a push with count<FIFO_DEPTH is stored; a push to a full FIFO is dropped and sets ovf_o[i].
REQ-017 SHALL assert full_o[i] combinationally from count==FIFO_DEPTH; full status comes from the count before the edge, so a push and a read in the same cycle on a full FIFO still drops the push.
REQ-018 SHALL implement a two-state output FSM: EMPTY (pndng_o=0) and VALID (pndng_o=1).
REQ-019 SHALL load the output register when the FSM is in EMPTY, or when it is in VALID with pop_i=1, and at least one FIFO is non-empty; it then pops the granted FIFO and enters or stays in VALID.
REQ-020 SHALL go from VALID to EMPTY when pop_i=1 and all FIFOs are empty.
REQ-021 SHALL ignore pop_i while the FSM is in EMPTY.
REQ-022 SHALL have no push-to-output bypass; a push at edge k is visible at pndng_o after edge k+1 at the earliest.
REQ-023 SHALL support back-to-back pops with no bubble while any FIFO is non-empty.
REQ-024 SHALL grant round-robin: search starts at last_grant+1, wraps modulo CHANNELS, and the first non-empty channel wins; last_grant updates on every load.
REQ-025 SHALL hold data_out_o, src_o and bcast_o stable while pndng_o=1 and pop_i=0.
REQ-026 SHALL wrap each FIFO's read/write pointers modulo FIFO_DEPTH; the count stays in the range 0..FIFO_DEPTH.

Reset
REQ-027 SHALL, on rst_i=1 at a clock edge, clear all FIFO counts and pointers, set last_grant to CHANNELS-1, and put the FSM in EMPTY.
REQ-028 SHALL drive these values after reset: pndng_o=0, data_out_o=0, src_o=0, bcast_o=0, ovf_o=0, full_o=0.
REQ-029 SHALL, when reset occurs mid-operation, discard all stored and pending packets and ignore pushes and pops in the reset cycle.

Configuration
REQ-030 SHALL, with MESH_ARB_BCAST_PRIO_EN defined, grant FIFO heads carrying BDCST over non-broadcast heads; among several broadcast heads, round-robin applies; a broadcast grant does not update last_grant.
REQ-031 SHALL, without MESH_ARB_BCAST_PRIO_EN, use pure round-robin per REQ-024; bcast_o is still generated.

Verification
REQ-032 SHALL test reset: push ch0 32'h0A00_0001, then assert rst_i for 1 cycle -> pndng_o=0 and full_o=0; no packet appears afterwards.
REQ-033 SHALL test fairness: push one packet into each of ch0..ch3 in the same cycle, pop each cycle -> src_o sequence 0,1,2,3 with no bubble; pndng_o falls after the 4th pop.
REQ-034 SHALL test overflow: 17 pushes to ch2 with FIFO_DEPTH=16 and no pops -> full_o[2]=1 after the 16th push; the 17th push is dropped and sets ovf_o[2]=1 sticky; draining yields exactly 16 packets in order.
REQ-035 SHALL test latency: push ch1 32'h1234_5678 at edge k -> pndng_o=1 and data_out_o=32'h1234_5678 after edge k+1; the value is held for 5 cycles with pop_i=0.
REQ-036 SHALL test broadcast priority with macro defined: last_grant=0, ch1 holds 32'h0500_0000, ch3 holds 32'hFF00_0000 -> ch3 is granted first with bcast_o=1, then ch1.
REQ-037 SHALL test the same stimulus as REQ-036 without the macro -> ch1 is granted first, then ch3 with bcast_o=1.
